// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter_pkg: shared size encodings, arbitration modes and grant FSM encodings
package sram_like_arbiter_pkg;
   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;
   localparam int ARB_RR = 0;
   localparam int ARB_FIXED = 1;
   localparam logic [0:0] ST_FREE = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;
endpackage

// File: rtl/sram_like_arbiter_order_fifo.sv
// order_fifo: records the channel id of each accepted request so responses route back in order
module order_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           push,
   input  logic [WIDTH-1:0]               din,
   input  logic                           pop,
   output logic [WIDTH-1:0]               dout,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wp, rp;
   // storage is not reset; only pointers define validity
   always_ff @(posedge clk)
      if (push) mem[wp] <= din;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk)
      if (!resetn) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   assign dout = mem[rp];
   assign empty = count == '0;
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: multiplexes NCH sram-like masters onto one downstream port with in-order responses
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int NCH = 2,
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int DEPTH = 4,
   parameter int ARB_MODE = 0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [NCH-1:0]        m_req,
   input  logic [NCH-1:0]        m_wr,
   input  logic [2*NCH-1:0]      m_size,
   input  logic [DW/8*NCH-1:0]   m_wstrb,
   input  logic [AW*NCH-1:0]     m_addr,
   input  logic [DW*NCH-1:0]     m_wdata,
   output logic [NCH-1:0]        m_addr_ok,
   output logic [NCH-1:0]        m_data_ok,
   output logic [DW-1:0]         m_rdata,
   output logic                  s_req,
   output logic                  s_wr,
   output logic [1:0]            s_size,
   output logic [DW/8-1:0]       s_wstrb,
   output logic [AW-1:0]         s_addr,
   output logic [DW-1:0]         s_wdata,
   input  logic                  s_addr_ok,
   input  logic                  s_data_ok,
   input  logic [DW-1:0]         s_rdata,
   output logic                  err
);
   localparam int SW = DW / 8;
   localparam int CHW = $clog2(NCH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   logic [0:0] state;
   logic [CHW-1:0] lock_ch, ptr, gnt, head, c;
   logic gnt_vld, hs, pop, empty;
   logic [CW-1:0] count;
   // grant: the locked channel while waiting for accept, else first requester from the priority start
   always_comb begin
      gnt = '0;
      gnt_vld = 1'b0;
      c = '0;
      if (state == ST_LOCKED) begin
         gnt = lock_ch;
         gnt_vld = m_req[lock_ch];
      end else
         for (int i = NCH - 1; i >= 0; i--) begin
            c = CHW'(((ARB_MODE == ARB_FIXED ? 0 : int'(ptr)) + i) % NCH);
            if (m_req[c]) begin
               gnt = c;
               gnt_vld = 1'b1;
            end
         end
   end
   // forward the granted channel's request fields, zero when nothing is granted
   always_comb begin
      s_wr = gnt_vld ? m_wr[gnt] : 1'b0;
      s_size = gnt_vld ? m_size[2*gnt +: 2] : '0;
      s_wstrb = gnt_vld ? m_wstrb[SW*gnt +: SW] : '0;
      s_addr = gnt_vld ? m_addr[AW*gnt +: AW] : '0;
      s_wdata = gnt_vld ? m_wdata[DW*gnt +: DW] : '0;
   end
   assign s_req = resetn && gnt_vld && count != FULL;
   assign hs = s_req && s_addr_ok;
   assign pop = resetn && s_data_ok && !empty;
   assign m_addr_ok = hs ? NCH'(1) << gnt : '0;
   assign m_data_ok = pop ? NCH'(1) << head : '0;
   assign m_rdata = s_rdata;
   order_fifo #(.WIDTH(CHW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .resetn(resetn),
      .push  (hs),
      .din   (gnt),
      .pop   (pop),
      .dout  (head),
      .empty (empty),
      .count (count)
   );
   // grant lock FSM, round-robin pointer and sticky protocol error
   always_ff @(posedge clk)
      if (!resetn) begin
         state <= ST_FREE;
         lock_ch <= '0;
         ptr <= '0;
         err <= 1'b0;
      end else begin
         if (hs && ARB_MODE != ARB_FIXED) ptr <= CHW'((int'(gnt) + 1) % NCH);
         if (s_data_ok && empty) err <= 1'b1;
         if (state == ST_LOCKED) begin
            if (!m_req[lock_ch]) begin
               state <= ST_FREE;
               err <= 1'b1;
            end else if (hs) state <= ST_FREE;
         end else if (s_req && !s_addr_ok) begin
            state <= ST_LOCKED;
            lock_ch <= gnt;
         end
      end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed vector table plus a full/same-cycle push-pop sequence
module tb_sram_like_arbiter;
   import sram_like_arbiter_pkg::*;
   localparam logic [31:0] A0 = 32'h1C00_0000;
   localparam logic [31:0] A1 = 32'h0000_0080;
   localparam logic [31:0] W0 = 32'hAAAA_5555;
   localparam logic [31:0] W1 = 32'h1234_5678;
   localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
   typedef struct {
      logic        rstn;
      logic [1:0]  req;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
      logic        e_sreq;
      logic [1:0]  e_aok;
      logic [1:0]  e_dok;
      logic [31:0] e_addr;
      logic        e_err;
   } vec_t;
   logic clk = 1'b0;
   logic resetn;
   logic [1:0] m_req, m_wr, m_addr_ok, m_data_ok;
   logic [3:0] m_size;
   logic [7:0] m_wstrb;
   logic [63:0] m_addr, m_wdata;
   logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
   logic s_req, s_wr, s_addr_ok, s_data_ok, err;
   logic [1:0] s_size;
   logic [3:0] s_wstrb;
   int checks = 0;
   int errors = 0;
   vec_t tv [38];
   always #5 clk = ~clk;
   sram_like_arbiter dut (
      .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
      .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
      .m_data_ok(m_data_ok), .m_rdata(m_rdata), .s_req(s_req), .s_wr(s_wr),
      .s_size(s_size), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata), .err(err)
   );
   function automatic vec_t v(logic rstn, logic [1:0] req, logic aok, logic dok, logic [31:0] rdata,
                              logic e_sreq, logic [1:0] e_aok, logic [1:0] e_dok, logic [31:0] e_addr, logic e_err);
      vec_t t;
      t.rstn = rstn; t.req = req; t.aok = aok; t.dok = dok; t.rdata = rdata;
      t.e_sreq = e_sreq; t.e_aok = e_aok; t.e_dok = e_dok; t.e_addr = e_addr; t.e_err = e_err;
      return t;
   endfunction
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic apply(vec_t t, string tag);
      logic [31:0] e_wdata;
      logic e_wr;
      logic [1:0] e_size;
      @(negedge clk);
      resetn = t.rstn; m_req = t.req; s_addr_ok = t.aok; s_data_ok = t.dok; s_rdata = t.rdata;
      #1;
      e_wr = t.e_addr == A1;
      e_wdata = t.e_addr == A1 ? W1 : t.e_addr == A0 ? W0 : 32'h0;
      e_size = t.e_addr == A1 ? SIZE_HALF : t.e_addr == A0 ? SIZE_WORD : 2'd0;
      chk({tag, " s_req"}, 32'(s_req), 32'(t.e_sreq));
      chk({tag, " m_addr_ok"}, 32'(m_addr_ok), 32'(t.e_aok));
      chk({tag, " m_data_ok"}, 32'(m_data_ok), 32'(t.e_dok));
      chk({tag, " s_addr"}, s_addr, t.e_addr);
      chk({tag, " s_wr"}, 32'(s_wr), 32'(e_wr));
      chk({tag, " s_size"}, 32'(s_size), 32'(e_size));
      chk({tag, " s_wdata"}, s_wdata, e_wdata);
      chk({tag, " m_rdata"}, m_rdata, t.rdata);
      chk({tag, " err"}, 32'(err), 32'(t.e_err));
   endtask
   initial begin
      tv[0]  = v(0, 2'b11, 1, 1, 0,    0, 2'b00, 2'b00, A0, 0);
      tv[1]  = v(1, 2'b11, 1, 0, 0,    1, 2'b01, 2'b00, A0, 0);
      tv[2]  = v(1, 2'b11, 1, 0, 0,    1, 2'b10, 2'b00, A1, 0);
      tv[3]  = v(1, 2'b11, 1, 0, 0,    1, 2'b01, 2'b00, A0, 0);
      tv[4]  = v(1, 2'b11, 1, 0, 0,    1, 2'b10, 2'b00, A1, 0);
      tv[5]  = v(1, 2'b11, 1, 0, 0,    0, 2'b00, 2'b00, A0, 0);
      tv[6]  = v(1, 2'b11, 1, 1, BEEF, 0, 2'b00, 2'b01, A0, 0);
      tv[7]  = v(1, 2'b11, 1, 0, 0,    1, 2'b01, 2'b00, A0, 0);
      tv[8]  = v(1, 2'b00, 0, 1, 1,    0, 2'b00, 2'b10, 0,  0);
      tv[9]  = v(1, 2'b00, 0, 1, 2,    0, 2'b00, 2'b01, 0,  0);
      tv[10] = v(1, 2'b00, 0, 1, 3,    0, 2'b00, 2'b10, 0,  0);
      tv[11] = v(1, 2'b00, 0, 1, 4,    0, 2'b00, 2'b01, 0,  0);
      tv[12] = v(1, 2'b00, 0, 1, 0,    0, 2'b00, 2'b00, 0,  0);
      tv[13] = v(1, 2'b00, 0, 0, 0,    0, 2'b00, 2'b00, 0,  1);
      tv[14] = v(0, 2'b00, 0, 0, 0,    0, 2'b00, 2'b00, 0,  1);
      tv[15] = v(1, 2'b00, 0, 0, 0,    0, 2'b00, 2'b00, 0,  0);
      tv[16] = v(1, 2'b01, 1, 0, 0,    1, 2'b01, 2'b00, A0, 0);
      tv[17] = v(1, 2'b10, 1, 0, 0,    1, 2'b10, 2'b00, A1, 0);
      tv[18] = v(1, 2'b00, 0, 1, BEEF, 0, 2'b00, 2'b01, 0,  0);
      tv[19] = v(1, 2'b00, 0, 1, 0,    0, 2'b00, 2'b10, 0,  0);
      tv[20] = v(1, 2'b01, 1, 0, 0,    1, 2'b01, 2'b00, A0, 0);
      tv[21] = v(1, 2'b01, 0, 0, 0,    1, 2'b00, 2'b00, A0, 0);
      tv[22] = v(1, 2'b11, 0, 0, 0,    1, 2'b00, 2'b00, A0, 0);
      tv[23] = v(1, 2'b11, 0, 0, 0,    1, 2'b00, 2'b00, A0, 0);
      tv[24] = v(1, 2'b11, 1, 0, 0,    1, 2'b01, 2'b00, A0, 0);
      tv[25] = v(1, 2'b11, 1, 0, 0,    1, 2'b10, 2'b00, A1, 0);
      tv[26] = v(1, 2'b00, 0, 1, 0,    0, 2'b00, 2'b01, 0,  0);
      tv[27] = v(1, 2'b00, 0, 1, 0,    0, 2'b00, 2'b01, 0,  0);
      tv[28] = v(1, 2'b00, 0, 1, 0,    0, 2'b00, 2'b10, 0,  0);
      tv[29] = v(1, 2'b01, 0, 0, 0,    1, 2'b00, 2'b00, A0, 0);
      tv[30] = v(1, 2'b00, 0, 0, 0,    0, 2'b00, 2'b00, 0,  0);
      tv[31] = v(1, 2'b00, 0, 0, 0,    0, 2'b00, 2'b00, 0,  1);
      tv[32] = v(0, 2'b00, 0, 0, 0,    0, 2'b00, 2'b00, 0,  1);
      tv[33] = v(1, 2'b11, 1, 0, 0,    1, 2'b01, 2'b00, A0, 0);
      tv[34] = v(1, 2'b11, 1, 0, 0,    1, 2'b10, 2'b00, A1, 0);
      tv[35] = v(0, 2'b11, 1, 1, 0,    0, 2'b00, 2'b00, A0, 0);
      tv[36] = v(1, 2'b00, 0, 1, 0,    0, 2'b00, 2'b00, 0,  0);
      tv[37] = v(1, 2'b00, 0, 0, 0,    0, 2'b00, 2'b00, 0,  1);
      resetn = 1'b0; m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
      m_wr = 2'b10;
      m_size = {SIZE_HALF, SIZE_WORD};
      m_wstrb = {4'h3, 4'hF};
      m_addr = {A1, A0};
      m_wdata = {W1, W0};
      repeat (2) @(posedge clk);
      for (int i = 0; i < 38; i++) apply(tv[i], $sformatf("row%0d", i));
      apply(v(1, 2'b11, 1, 0, 0, 1, 2'b01, 2'b00, A0, 1), "fill0");
      apply(v(1, 2'b11, 1, 0, 0, 1, 2'b10, 2'b00, A1, 1), "fill1");
      apply(v(1, 2'b11, 1, 0, 0, 1, 2'b01, 2'b00, A0, 1), "fill2");
      apply(v(1, 2'b11, 1, 0, 0, 1, 2'b10, 2'b00, A1, 1), "fill3");
      apply(v(1, 2'b11, 1, 1, 7, 0, 2'b00, 2'b01, A0, 1), "full_pop");
      apply(v(1, 2'b11, 1, 1, 8, 1, 2'b01, 2'b10, A0, 1), "push_pop");
      apply(v(1, 2'b11, 1, 0, 0, 1, 2'b10, 2'b00, A1, 1), "refill");
      apply(v(1, 2'b11, 1, 0, 0, 0, 2'b00, 2'b00, A0, 1), "full_again");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
